// File: rtl/regfile_mp.sv
// ==================================================================
// regfile_mp : multi-port register file with busy-bit scoreboard
// Option REGFILE_BYPASS_EN forwards same-cycle writes to read ports.
// Revision: 1.0
// ==================================================================
`default_nettype none

module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRP   = 2,
  parameter int NWP   = 2,
  localparam int AW   = $clog2(NREGS),
  localparam int CW   = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRP*AW-1:0]    ra,
  output logic [NRP*XLEN-1:0]  rdata,
  output logic [NRP-1:0]       rbusy,
  input  logic [NWP-1:0]       we,
  input  logic [NWP*AW-1:0]    wa,
  input  logic [NWP*XLEN-1:0]  wd,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  output logic [CW-1:0]        busy_cnt
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  // Ascending port order lets the higher-index port win; issue is applied
  // after the write clears so a same-cycle set takes priority.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    busy_d = busy_q;
    for (int w = 0; w < NWP; w++) begin
      if (we[w] && (wa[w*AW +: AW] != '0)) begin
        regs_d[wa[w*AW +: AW]] = wd[w*XLEN +: XLEN];
        busy_d[wa[w*AW +: AW]] = 1'b0;
      end
    end
    if (iss_valid && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    cnt_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d = cnt_d + CW'(busy_d[r]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_stored;

    assign rd_addr   = ra[p*AW +: AW];
    assign rd_stored = (rd_addr == '0) ? '0 : regs_q[rd_addr];

`ifdef REGFILE_BYPASS_EN
    logic            byp_hit;
    logic [XLEN-1:0] byp_data;

    always_comb begin
      byp_hit  = 1'b0;
      byp_data = rd_stored;
      for (int w = 0; w < NWP; w++) begin
        if (we[w] && (wa[w*AW +: AW] != '0) && (wa[w*AW +: AW] == rd_addr)) begin
          byp_hit  = 1'b1;
          byp_data = wd[w*XLEN +: XLEN];
        end
      end
    end

    // Outputs are masked in reset so bypassed write data cannot leak out.
    assign rdata[p*XLEN +: XLEN] = rst_n ? byp_data : '0;
    assign rbusy[p] = rst_n & (byp_hit ? (iss_valid && (iss_rd == rd_addr))
                                       : busy_q[rd_addr]);
`else
    assign rdata[p*XLEN +: XLEN] = rst_n ? rd_stored : '0;
    assign rbusy[p] = rst_n & busy_q[rd_addr];
`endif
  end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning register data width in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning register count (power of 2, >=2); AW = clog2(NREGS).
REQ-003 The block SHALL have parameter NRP, default 2, meaning number of read ports (1..4).
REQ-004 The block SHALL have parameter NWP, default 2, meaning number of write ports (1..2).
REQ-005 The block SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port ra, input, NRP*AW bits: read addresses, port p at [p*AW +: AW].
REQ-008 The block SHALL have port rdata, output, NRP*XLEN bits: read data, port p at [p*XLEN +: XLEN].
REQ-009 The block SHALL have port rbusy, output, NRP bits: read register has a pending write.
REQ-010 The block SHALL have port we, input, NWP bits: write enables.
REQ-011 The block SHALL have port wa, input, NWP*AW bits: write addresses.
REQ-012 The block SHALL have port wd, input, NWP*XLEN bits: write data.
REQ-013 The block SHALL have port iss_valid, input, 1 bit: an instruction issues this cycle.
REQ-014 The block SHALL have port iss_rd, input, AW bits: destination register of the issuing instruction.
REQ-015 The block SHALL have port busy_cnt, output, AW+1 bits: number of registers currently marked busy.

Function
REQ-016 Reads SHALL be combinational (zero latency); register 0 SHALL always read 0 and never be busy.
REQ-017 On a clock edge, each port w with we[w]=1 and wa!=0 SHALL write wd into register wa; the write is visible to reads in the following cycle.
REQ-018 When two write ports target the same nonzero register in one cycle, the higher-index port SHALL win for both stored data and bypass.
REQ-019 The scoreboard SHALL hold one busy bit per register; iss_valid=1 with iss_rd!=0 SHALL set busy[iss_rd] at the clock edge.
REQ-020 A write (any port, we=1, wa!=0) SHALL clear busy[wa] at the clock edge; a write to a non-busy register SHALL still update data and leave busy at 0.
REQ-021 When an issue and a write target the same register in one cycle, set SHALL win (busy remains 1, data still written).
REQ-022 rbusy[p] SHALL equal busy[ra_p], registered state, except as modified by REQ-027.
REQ-023 busy_cnt SHALL be a registered count equal to the popcount of busy bits after each edge; range 0..NREGS-1.
REQ-024 Simultaneous writes on two ports to different registers SHALL both complete in the same cycle.

Reset
REQ-025 While rst_n=0, all registers SHALL be 0, all busy bits 0, and busy_cnt 0; rdata SHALL read 0 and rbusy 0 for every address.
REQ-026 Reset asserted mid-operation SHALL discard any same-cycle write and issue; the first edge after release SHALL operate normally.

Configuration
REQ-027 With macro REGFILE_BYPASS_EN defined, a read whose ra matches a same-cycle enabled write (nonzero) SHALL return that wd (REQ-018 priority), and rbusy SHALL be 0 for that port unless iss_valid also targets that register this cycle; without the macro, reads SHALL return stored data only and rbusy SHALL reflect registered busy only.

Verification
REQ-028 Reset, then read all registers -> every rdata=0, rbusy=0, busy_cnt=0.
REQ-029 Write x5=0xDEADBEEF on port 0, read ra0=5 the same cycle -> 0xDEADBEEF with REGFILE_BYPASS_EN, 0 without; next cycle 0xDEADBEEF in both builds.
REQ-030 Ports 0 and 1 both write x7 (0x11, 0x22) -> x7 reads 0x22; write x0=0xFFFF -> x0 reads 0.
REQ-031 Issue rd=3, next cycle rbusy=1 and busy_cnt=1; write x3=0x55 -> busy clears, busy_cnt=0; issue rd=3 and write x3 same cycle -> busy stays 1, x3=new data.
REQ-032 Issue rd=9 and write x9, then assert rst_n=0 mid-cycle -> rbusy=0, x9 reads 0, busy_cnt=0 immediately.
